// File: rtl/supervisor_bombas.sv
// Motor feed arbiter for two pump controllers: grants at most one motor at a time,
// enforcing minimum/maximum on-time, a dead gap between runs, and a latched fault.
module supervisor_bombas #(
    parameter int MIN_ON = 8,
    parameter int MAX_ON = 32,
    parameter int DEAD   = 2,
    parameter int W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_b1,
    input  logic       req_b2,
    input  logic       alarme_b1,
    input  logic       alarme_b2,
    input  logic       parada,
    input  logic       rec,
    output logic       m1,
    output logic       m2,
    output logic       alarme_geral,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN_B1 = 3'd1,
        S_RUN_B2 = 3'd2,
        S_DEAD   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam logic [W-1:0] MIN_LIM  = W'(MIN_ON - 1);
    localparam logic [W-1:0] MAX_LIM  = W'(MAX_ON - 1);
    localparam logic [W-1:0] DEAD_LIM = W'(DEAD - 1);

    // ultimo encoding: 0 = pump 1 served last, 1 = pump 2 served last
    localparam logic ULT_B1 = 1'b0;
    localparam logic ULT_B2 = 1'b1;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           ultimo_q, ultimo_d;
    logic           falha;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ultimo_q <= ULT_B2;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ultimo_q <= ultimo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ultimo_d = ultimo_q;
        falha    = alarme_b1 | alarme_b2 | parada;

        if (falha) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_b1 && req_b2)
                        state_d = (ultimo_q == ULT_B1) ? S_RUN_B2 : S_RUN_B1;
                    else if (req_b1)
                        state_d = S_RUN_B1;
                    else if (req_b2)
                        state_d = S_RUN_B2;
                end
                S_RUN_B1: begin
                    if ((!req_b1 && cnt_q >= MIN_LIM) || (req_b2 && cnt_q >= MAX_LIM))
                        state_d = S_DEAD;
                end
                S_RUN_B2: begin
                    if ((!req_b2 && cnt_q >= MIN_LIM) || (req_b1 && cnt_q >= MAX_LIM))
                        state_d = S_DEAD;
                end
                S_DEAD: begin
                    if (cnt_q == DEAD_LIM)
                        state_d = S_IDLE;
                end
                S_FAULT: begin
                    if (rec)
                        state_d = S_DEAD;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Any departure from a run (normal exit or fault) records who was served,
        // so fairness survives a fault interrupting a run.
        if (state_q == S_RUN_B1 && state_d != S_RUN_B1)
            ultimo_d = ULT_B1;
        else if (state_q == S_RUN_B2 && state_d != S_RUN_B2)
            ultimo_d = ULT_B2;

        if (state_d != state_q)
            cnt_d = '0;
        else if (cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;
    end

    assign m1           = (state_q == S_RUN_B1);
    assign m2           = (state_q == S_RUN_B2);
    assign alarme_geral = (state_q == S_FAULT);
    assign estado       = state_q;

endmodule

// File: tb/tb_supervisor_bombas.sv
// Self-checking bench for supervisor_bombas: directed vector table plus
// multi-cycle sequences, expected state queued at drive time and checked after the edge.
module tb_supervisor_bombas;

    logic       clk;
    logic       rst;
    logic       req_b1, req_b2, alarme_b1, alarme_b2, parada, rec;
    logic       m1, m2, alarme_geral;
    logic [2:0] estado;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] sb_q[$];

    localparam logic [2:0] IDLE = 3'd0, RB1 = 3'd1, RB2 = 3'd2, DEADS = 3'd3, FLT = 3'd4;

    supervisor_bombas #(.MIN_ON(8), .MAX_ON(32), .DEAD(2), .W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_b1       (req_b1),
        .req_b2       (req_b2),
        .alarme_b1    (alarme_b1),
        .alarme_b2    (alarme_b2),
        .parada       (parada),
        .rec          (rec),
        .m1           (m1),
        .m2           (m2),
        .alarme_geral (alarme_geral),
        .estado       (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, r1, r2, a1, a2, par, rc;
        logic [2:0] est;
    } vec_t;

    vec_t tbl[16];

    // One transaction: drive on the falling edge, queue the expected state,
    // and check all outputs just after the rising edge that samples the inputs.
    task automatic step(input logic i_rst, input logic i_r1, input logic i_r2,
                        input logic i_a1, input logic i_a2, input logic i_par,
                        input logic i_rec, input logic [2:0] e, input string nm);
        logic [2:0] ex;
        logic [5:0] want, got;
        @(negedge clk);
        rst = i_rst; req_b1 = i_r1; req_b2 = i_r2;
        alarme_b1 = i_a1; alarme_b2 = i_a2; parada = i_par; rec = i_rec;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            ex   = sb_q.pop_front();
            want = {ex, ex == RB1, ex == RB2, ex == FLT};
            got  = {estado, m1, m2, alarme_geral};
            if (got !== want) begin
                n_err++;
                $display("FAIL %s: got estado=%0d m1=%b m2=%b ag=%b, want estado=%0d m1=%b m2=%b ag=%b",
                         nm, got[5:3], got[2], got[1], got[0], want[5:3], want[2], want[1], want[0]);
            end else begin
                $display("[%0t] %s estado=%0d m1=%b m2=%b ag=%b ok", $time, nm, estado, m1, m2, alarme_geral);
            end
        end
    endtask

    task automatic rep(input int n, input logic i_r1, input logic i_r2,
                       input logic [2:0] e, input string nm);
        for (int i = 0; i < n; i++)
            step(1'b0, i_r1, i_r2, 1'b0, 1'b0, 1'b0, 1'b0, e, nm);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, "reset");
    endtask

    initial begin
        rst = 1'b1; req_b1 = 1'b0; req_b2 = 1'b0;
        alarme_b1 = 1'b0; alarme_b2 = 1'b0; parada = 1'b0; rec = 1'b0;

        //            rst r1 r2 a1 a2 par rec  expected
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, IDLE };  // reset
        tbl[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, IDLE };  // reset beats falha
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, IDLE };  // idle
        tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, FLT  };  // parada beats request
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, FLT  };  // rec ignored under falha
        tbl[5]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, FLT  };  // fault latched
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, DEADS};  // acknowledge
        tbl[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, DEADS};  // requests ignored in dead
        tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, IDLE };  // dead gap over
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, RB1  };  // first tie to pump 1
        tbl[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, RB1  };  // drop before min on
        tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, FLT  };  // alarme_b1 mid run
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, DEADS};  // acknowledge
        tbl[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, DEADS};
        tbl[14] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, IDLE };
        tbl[15] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, RB2  };  // single request pump 2

        for (int i = 0; i < 16; i++)
            step(tbl[i].rst, tbl[i].r1, tbl[i].r2, tbl[i].a1, tbl[i].a2,
                 tbl[i].par, tbl[i].rc, tbl[i].est, $sformatf("tbl%0d", i));

        // Minimum on-time from a one-cycle request
        do_reset();
        rep(1, 1'b1, 1'b0, RB1,   "minon_grant");
        rep(7, 1'b0, 1'b0, RB1,   "minon_hold");
        rep(2, 1'b0, 1'b0, DEADS, "minon_dead");
        rep(3, 1'b0, 1'b0, IDLE,  "minon_idle");

        // Round-robin under continuous contention
        do_reset();
        for (int r = 0; r < 2; r++) begin
            rep(32, 1'b1, 1'b1, RB1,   "rr_m1");
            rep(2,  1'b1, 1'b1, DEADS, "rr_dead1");
            rep(1,  1'b1, 1'b1, IDLE,  "rr_idle1");
            rep(32, 1'b1, 1'b1, RB2,   "rr_m2");
            rep(2,  1'b1, 1'b1, DEADS, "rr_dead2");
            rep(1,  1'b1, 1'b1, IDLE,  "rr_idle2");
        end
        rep(1, 1'b1, 1'b1, RB1, "rr_again");

        // Fault latch during RUN_B1, rec held through the alarm pulse
        do_reset();
        rep(11, 1'b1, 1'b0, RB1, "fl_run");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, FLT, "fl_enter");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, FLT, "fl_rec_ign");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FLT, "fl_held");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DEADS, "fl_ack");
        rep(1, 1'b0, 1'b1, DEADS, "fl_dead");
        rep(1, 1'b0, 1'b1, IDLE,  "fl_idle");
        rep(1, 1'b0, 1'b1, RB2,   "fl_regrant");

        // Parada in the first DEAD cycle
        do_reset();
        rep(1, 1'b1, 1'b0, RB1,   "pd_grant");
        rep(7, 1'b0, 1'b0, RB1,   "pd_hold");
        rep(1, 1'b0, 1'b0, DEADS, "pd_dead");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FLT, "pd_parada");
        rep(3, 1'b1, 1'b1, FLT, "pd_persist");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, FLT, "pd_rec_ign");

        // Reset mid-run, then the first tie goes to pump 1
        do_reset();
        rep(6, 1'b0, 1'b1, RB2, "rm_run");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, "rm_reset");
        rep(1, 1'b1, 1'b1, RB1, "rm_regrant");

        // Early request drop in RUN_B2 with pump 1 waiting
        do_reset();
        rep(1, 1'b0, 1'b1, RB2,   "ed_grant");
        rep(3, 1'b1, 1'b1, RB2,   "ed_both");
        rep(4, 1'b1, 1'b0, RB2,   "ed_minon");
        rep(2, 1'b1, 1'b0, DEADS, "ed_dead");
        rep(1, 1'b1, 1'b0, IDLE,  "ed_idle");
        rep(1, 1'b1, 1'b0, RB1,   "ed_m1");

        // Counter saturation: a long solo run still releases on drop
        do_reset();
        rep(1,   1'b1, 1'b0, RB1,   "sat_grant");
        rep(256, 1'b1, 1'b0, RB1,   "sat_hold");
        rep(1,   1'b0, 1'b0, DEADS, "sat_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/supervisor_bombas.md
# supervisor_bombas

Supervisor that shares the single motor power feed between the two pump controllers. It takes each controller's run request and alarm, and grants the motor to at most one pump at a time. It enforces a minimum on-time, a maximum on-time while the other pump is waiting, and a dead gap between motor switchovers. Any alarm latches a global fault. The block sits between the per-pump controllers and the motor drivers and is the only block that drives `m1`/`m2`.

## Interface
Parameters:
- `MIN_ON`, 8: minimum cycles a granted motor stays on.
- `MAX_ON`, 32: cycles after which a running pump is preempted if the other pump is requesting.
- `DEAD`, 2: cycles spent in DEAD with both motors off after every run.
- `W`, 8: width of the cycle counter. `MAX_ON` must be less than 2^W.

Ports:
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `req_b1`  in  1: pump 1 controller wants its motor on (level).
- `req_b2`  in  1: pump 2 controller wants its motor on (level).
- `alarme_b1`  in  1: pump 1 sensor-inconsistency alarm (level).
- `alarme_b2`  in  1: pump 2 sensor-inconsistency alarm (level).
- `parada`  in  1: emergency stop (level).
- `rec`  in  1: operator acknowledge, used to clear a latched fault.
- `m1`  out  1: motor 1 drive.
- `m2`  out  1: motor 2 drive.
- `alarme_geral`  out  1: latched fault indicator.
- `estado`  out  3: current state. IDLE=0, RUN_B1=1, RUN_B2=2, DEAD=3, FAULT=4.

## Operation
Registers:
- `estado`.
- `cnt` (W bits): cleared on every state change, otherwise incremented each cycle; saturates at all-ones.
- `ultimo`: the pump served most recently.

Outputs are Moore outputs decoded from the registered state:
- `m1 = (estado==RUN_B1)`
- `m2 = (estado==RUN_B2)`
- `alarme_geral = (estado==FAULT)`

`m1` and `m2` are never both 1.

Fault entry:
- Define `falha = alarme_b1 | alarme_b2 | parada`.
- From any state, `falha` high at an edge moves the block to FAULT.
- Fault entry has top priority over every transition below.

Transitions:
- IDLE:
  - Only `req_b1` high: go to RUN_B1.
  - Only `req_b2` high: go to RUN_B2.
  - Both high: grant the pump that is not `ultimo`.
  - Neither high: stay in IDLE.
- RUN_Bx:
  - Go to DEAD when `!req_bx && cnt>=MIN_ON-1`. A request dropping earlier is ignored until `MIN_ON` is reached.
  - Also go to DEAD when the other request is high and `cnt>=MAX_ON-1` (preemption).
  - On exit, `ultimo` is set to x.
- DEAD: go to IDLE when `cnt==DEAD-1`. Requests are ignored while in DEAD.
- FAULT:
  - Go to DEAD when `!falha && rec`.
  - `rec` is ignored while `falha` is high.
  - `ultimo` is preserved through the fault.

Reset:
- `estado` = IDLE, `cnt` = 0, `ultimo` = B2 (so pump 1 wins the first tie).
- `m1` = 0, `m2` = 0, `alarme_geral` = 0.
- Reset overrides all inputs, including `falha`.

## Timing
- Grant latency: a request sampled high in IDLE at edge k gives `mx=1` from edge k.
- Minimum on-time: `mx` stays high for at least `MIN_ON` cycles.
- Preemption: under continuous contention, each pump runs exactly `MAX_ON` cycles per turn.
- Dead gap: between any motor falling and the next motor rising, both motors are low for at least `DEAD+1` cycles (DEAD state plus one IDLE cycle).
- Fault latency: `falha` sampled at edge k gives `m1=m2=0` and `alarme_geral=1` from edge k. There is no combinational path from input to output.
- Fault recovery: `rec` accepted at edge k gives `alarme_geral=0` from edge k. The earliest new grant is at edge k+DEAD+1.
- Simultaneous events in one cycle:
  - `falha` together with any request or `rec`: FAULT wins.
  - Request drop together with preemption: go to DEAD once; `ultimo` is updated once.
- Reset mid-run: motor low the edge after `rst` is sampled. No dead gap is enforced after reset.

## Test plan
All scenarios use default parameters.
- Min on-time:
  - Stimulus: from reset, `req_b1`=1 for one cycle.
  - Required: `m1` high exactly 8 cycles, then `estado` = 3 for 2 cycles, then 0, with `m2` low throughout.
- Round-robin under contention:
  - Stimulus: `req_b1`=`req_b2`=1 continuously from reset.
  - Required: `m1` high 32 cycles, both low 3, `m2` high 32, both low 3, `m1` again. The pattern repeats.
- Fault latch:
  - Stimulus: `alarme_b2` pulses at cycle 10 of RUN_B1, and `rec` is held high during the pulse.
  - Required: `m1`=0 and `alarme_geral`=1 at the next edge. The fault is held until `alarme_b2`=0 with `rec`=1. The next grant follows 3 cycles later, to pump 2.
- Parada in DEAD:
  - Stimulus: `parada` asserted in the first DEAD cycle.
  - Required: `estado`=4 at the next edge, and the fault persists across requests.
- Reset mid-run:
  - Stimulus: `rst` at cycle 5 of RUN_B2, then both requests high.
  - Required: `m2`=0 at the next edge, `estado`=0, and the next grant goes to pump 1.
- Early request drop during RUN_B2:
  - Stimulus: `req_b2` falls at cycle 3 of RUN_B2 while `req_b1`=1.
  - Required: `m2` stays high until cycle 8, then dead gap, then `m1`.
